// File: rtl/l2_pkg.sv
// Shared types and helpers for the L2 host request scheduler.
// Types reflect the default configuration; modules size their own signals from parameters.
package l2_pkg;

    localparam int unsigned NSTRMS_DEF   = 32'd64;
    localparam int unsigned CHANNELS_DEF = 32'd4;
    localparam int unsigned NTAGS_DEF    = 32'd32;

    typedef logic [$clog2(NTAGS_DEF)-1:0]    tag_t;
    typedef logic [$clog2(NSTRMS_DEF)-1:0]   sid_t;
    typedef logic [$clog2(CHANNELS_DEF)-1:0] chan_t;

    // Global stream ID is the channel number placed above the channel-local stream ID.
    function automatic logic [31:0] compose_sid(input logic [31:0] chan,
                                                input logic [31:0] lsid,
                                                input int unsigned lsid_width);
        compose_sid = (chan << lsid_width) | lsid;
    endfunction

endpackage

// File: rtl/l2_tag_alloc.sv
// Host tag pool: free bitmap, lowest-free-tag encoder, tag->SID table and allocated-tag count.
// A tag freed in a cycle only becomes allocatable in the next cycle.
module l2_tag_alloc
    import l2_pkg::*;
#(
    parameter  int unsigned ntags     = 32'd32,
    parameter  int unsigned sid_width = 32'd6,
    localparam int unsigned tag_width = $clog2(ntags)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_v,
    input  logic [sid_width-1:0] alloc_sid,
    output logic [tag_width-1:0] alloc_tag,
    input  logic                 free_v,
    input  logic [tag_width-1:0] free_tag,
    output logic [sid_width-1:0] free_sid,
    output logic                 free_err,
    output logic                 has_free,
    output logic [tag_width:0]   out_cnt
);

    logic [ntags-1:0]     free_r;
    logic [sid_width-1:0] table_r [ntags];
    logic [tag_width:0]   cnt_r;
    logic [tag_width-1:0] low_s;
    logic                 free_ok_s;
    logic [ntags-1:0]     alloc_mask_s;
    logic [ntags-1:0]     free_mask_s;

    // Lowest-index free tag plus the set/clear masks for this cycle's bitmap update
    always_comb begin
        low_s = '0;
        for (int i = int'(ntags) - 32'sd1; i >= 32'sd0; i--) begin
            if (free_r[i]) begin
                low_s = tag_width'(i);
            end else begin
                low_s = low_s;
            end
        end
        free_ok_s = free_v & ~free_r[free_tag];
        if (alloc_v) begin
            alloc_mask_s = {{(ntags-1){1'b0}}, 1'b1} << low_s;
        end else begin
            alloc_mask_s = '0;
        end
        if (free_ok_s) begin
            free_mask_s = {{(ntags-1){1'b0}}, 1'b1} << free_tag;
        end else begin
            free_mask_s = '0;
        end
    end

    assign alloc_tag = low_s;
    assign has_free  = |free_r;
    assign free_err  = free_v & free_r[free_tag];
    assign free_sid  = table_r[free_tag];
    assign out_cnt   = cnt_r;

    // Free bitmap and allocated-tag count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_r <= '1;
            cnt_r  <= '0;
        end else begin
            free_r <= (free_r & ~alloc_mask_s) | free_mask_s;
            case ({alloc_v, free_ok_s})
                2'b10:   cnt_r <= cnt_r + {{tag_width{1'b0}}, 1'b1};
                2'b01:   cnt_r <= cnt_r - {{tag_width{1'b0}}, 1'b1};
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Tag to global SID table, written on allocation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ntags); i++) begin
                table_r[i] <= '0;
            end
        end else if (alloc_v) begin
            table_r[low_s] <= alloc_sid;
        end else begin
            table_r[low_s] <= table_r[low_s];
        end
    end

endmodule

// File: rtl/l2_host_req_sched.sv
// Round-robin host request scheduler with tag allocation and tag-based response return.
// Optional per-stream outstanding limit: define L2_REQ_SCHED_STRM_LIMIT_EN.
module l2_host_req_sched
    import l2_pkg::*;
#(
    parameter  int unsigned addr_width      = 32'd64,
    parameter  int unsigned nstrms          = 32'd64,
    parameter  int unsigned channels        = 32'd4,
    parameter  int unsigned l2_nstrms       = nstrms / channels,
    parameter  int unsigned ntags           = 32'd32,
    parameter  int unsigned max_out         = 32'd4,
    localparam int unsigned nstrms_width    = $clog2(nstrms),
    localparam int unsigned chan_width      = $clog2(channels),
    localparam int unsigned l2_nstrms_width = $clog2(l2_nstrms),
    localparam int unsigned tag_width       = $clog2(ntags)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [channels-1:0]                 i_req_v,
    output logic [channels-1:0]                 i_req_r,
    input  logic [channels*l2_nstrms_width-1:0] i_req_sid,
    input  logic [channels*addr_width-1:0]      i_req_ea,
    output logic                                o_req_v,
    input  logic                                o_req_r,
    output logic [tag_width-1:0]                o_req_tag,
    output logic [nstrms_width-1:0]             o_req_sid,
    output logic [addr_width-1:0]               o_req_ea,
    input  logic                                i_rsp_v,
    output logic                                i_rsp_r,
    input  logic [tag_width-1:0]                i_rsp_tag,
    output logic                                o_rsp_v,
    input  logic                                o_rsp_r,
    output logic [nstrms_width-1:0]             o_rsp_sid,
    output logic [tag_width:0]                  o_out_cnt,
    output logic                                o_err
);

    logic [nstrms_width-1:0] gsid_s [channels];
    logic [channels-1:0]     elig_s;
    logic [chan_width-1:0]   rr_ptr_r;
    logic [chan_width-1:0]   arb_idx_s;
    logic [chan_width-1:0]   win_s;
    logic                    found_s;
    logic                    can_load_s;
    logic                    accept_s;
    logic                    rsp_acc_s;
    logic [nstrms_width-1:0] win_sid_s;
    logic [addr_width-1:0]   win_ea_s;

    logic [tag_width-1:0]    alloc_tag_s;
    logic [nstrms_width-1:0] free_sid_s;
    logic                    free_err_s;
    logic                    has_free_s;

    logic                    req_v_r;
    logic [tag_width-1:0]    req_tag_r;
    logic [nstrms_width-1:0] req_sid_r;
    logic [addr_width-1:0]   req_ea_r;
    logic                    rsp_v_r;
    logic [nstrms_width-1:0] rsp_sid_r;
    logic                    err_r;

`ifdef L2_REQ_SCHED_STRM_LIMIT_EN
    localparam int unsigned cnt_width = $clog2(max_out + 32'd1);

    logic [cnt_width-1:0] strm_cnt_r [nstrms];
    logic [nstrms-1:0]    strm_inc_s;
    logic [nstrms-1:0]    strm_dec_s;
`endif

    // Per-channel global SID and eligibility
    always_comb begin
        for (int c = 0; c < int'(channels); c++) begin
            gsid_s[c] = nstrms_width'(compose_sid(32'(c),
                            32'(i_req_sid[c*l2_nstrms_width +: l2_nstrms_width]),
                            l2_nstrms_width));
`ifdef L2_REQ_SCHED_STRM_LIMIT_EN
            elig_s[c] = i_req_v[c] & has_free_s &
                        (strm_cnt_r[gsid_s[c]] < cnt_width'(max_out));
`else
            elig_s[c] = i_req_v[c] & has_free_s;
`endif
        end
    end

    // Round-robin search starting at rr_ptr; index wraps naturally since channels is a power of two
    always_comb begin
        found_s   = 1'b0;
        win_s     = '0;
        arb_idx_s = '0;
        for (int k = 0; k < int'(channels); k++) begin
            arb_idx_s = rr_ptr_r + chan_width'(k);
            if (!found_s && elig_s[arb_idx_s]) begin
                found_s = 1'b1;
                win_s   = arb_idx_s;
            end else begin
                found_s = found_s;
                win_s   = win_s;
            end
        end
    end

    // Winner field selection
    always_comb begin
        win_ea_s  = '0;
        win_sid_s = gsid_s[win_s];
        for (int c = 0; c < int'(channels); c++) begin
            if (win_s == chan_width'(c)) begin
                win_ea_s = i_req_ea[c*addr_width +: addr_width];
            end else begin
                win_ea_s = win_ea_s;
            end
        end
    end

    assign can_load_s = ~req_v_r | o_req_r;
    assign accept_s   = can_load_s & found_s;
    assign i_req_r    = accept_s ? ({{(channels-1){1'b0}}, 1'b1} << win_s) : '0;
    assign i_rsp_r    = ~rsp_v_r | o_rsp_r;
    assign rsp_acc_s  = i_rsp_v & i_rsp_r;

    l2_tag_alloc #(
        .ntags     (ntags),
        .sid_width (nstrms_width)
    ) u_tag_alloc (
        .clk       (clk),
        .reset     (reset),
        .alloc_v   (accept_s),
        .alloc_sid (win_sid_s),
        .alloc_tag (alloc_tag_s),
        .free_v    (rsp_acc_s),
        .free_tag  (i_rsp_tag),
        .free_sid  (free_sid_s),
        .free_err  (free_err_s),
        .has_free  (has_free_s),
        .out_cnt   (o_out_cnt)
    );

    // Host request output stage and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_v_r   <= 1'b0;
            req_tag_r <= '0;
            req_sid_r <= '0;
            req_ea_r  <= '0;
            rr_ptr_r  <= '0;
        end else if (accept_s) begin
            req_v_r   <= 1'b1;
            req_tag_r <= alloc_tag_s;
            req_sid_r <= win_sid_s;
            req_ea_r  <= win_ea_s;
            rr_ptr_r  <= win_s + {{(chan_width-1){1'b0}}, 1'b1};
        end else if (o_req_r) begin
            req_v_r   <= 1'b0;
        end else begin
            req_v_r   <= req_v_r;
        end
    end

    // Response stage; responses to unallocated tags are dropped and latch the error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_v_r   <= 1'b0;
            rsp_sid_r <= '0;
            err_r     <= 1'b0;
        end else begin
            err_r <= err_r | (rsp_acc_s & free_err_s);
            if (rsp_acc_s && !free_err_s) begin
                rsp_v_r   <= 1'b1;
                rsp_sid_r <= free_sid_s;
            end else if (o_rsp_r) begin
                rsp_v_r   <= 1'b0;
            end else begin
                rsp_v_r   <= rsp_v_r;
            end
        end
    end

`ifdef L2_REQ_SCHED_STRM_LIMIT_EN
    // Per-stream increment/decrement strobes
    always_comb begin
        for (int s = 0; s < int'(nstrms); s++) begin
            strm_inc_s[s] = accept_s & (win_sid_s == nstrms_width'(s));
            strm_dec_s[s] = rsp_acc_s & ~free_err_s & (free_sid_s == nstrms_width'(s));
        end
    end

    // Per-stream outstanding counters; simultaneous inc and dec cancel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < int'(nstrms); s++) begin
                strm_cnt_r[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(nstrms); s++) begin
                case ({strm_inc_s[s], strm_dec_s[s]})
                    2'b10:   strm_cnt_r[s] <= strm_cnt_r[s] + {{(cnt_width-1){1'b0}}, 1'b1};
                    2'b01:   strm_cnt_r[s] <= strm_cnt_r[s] - {{(cnt_width-1){1'b0}}, 1'b1};
                    default: strm_cnt_r[s] <= strm_cnt_r[s];
                endcase
            end
        end
    end
`endif

    assign o_req_v   = req_v_r;
    assign o_req_tag = req_tag_r;
    assign o_req_sid = req_sid_r;
    assign o_req_ea  = req_ea_r;
    assign o_rsp_v   = rsp_v_r;
    assign o_rsp_sid = rsp_sid_r;
    assign o_err     = err_r;

endmodule

// File: tb/tb_l2_host_req_sched.sv
// Scoreboard bench for l2_host_req_sched (default parameters; expectations follow
// L2_REQ_SCHED_STRM_LIMIT_EN when it is defined).
module tb_l2_host_req_sched;

    localparam int unsigned AW  = 64;
    localparam int unsigned CH  = 4;
    localparam int unsigned L2W = 4;
    localparam int unsigned TW  = 5;
    localparam int unsigned SW  = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [CH-1:0]    i_req_v;
    logic [CH-1:0]    i_req_r;
    logic [CH*L2W-1:0] i_req_sid;
    logic [CH*AW-1:0] i_req_ea;
    logic             o_req_v;
    logic             o_req_r;
    logic [TW-1:0]    o_req_tag;
    logic [SW-1:0]    o_req_sid;
    logic [AW-1:0]    o_req_ea;
    logic             i_rsp_v;
    logic             i_rsp_r;
    logic [TW-1:0]    i_rsp_tag;
    logic             o_rsp_v;
    logic             o_rsp_r;
    logic [SW-1:0]    o_rsp_sid;
    logic [TW:0]      o_out_cnt;
    logic             o_err;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [SW-1:0] sid;
        logic [AW-1:0] ea;
    } req_exp_t;

    req_exp_t      req_q[$];
    logic [SW-1:0] rsp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_host_req_sched #(
        .addr_width (64), .nstrms (64), .channels (4),
        .l2_nstrms  (16), .ntags  (32), .max_out  (4)
    ) dut (
        .clk (clk), .reset (reset),
        .i_req_v (i_req_v), .i_req_r (i_req_r), .i_req_sid (i_req_sid), .i_req_ea (i_req_ea),
        .o_req_v (o_req_v), .o_req_r (o_req_r), .o_req_tag (o_req_tag),
        .o_req_sid (o_req_sid), .o_req_ea (o_req_ea),
        .i_rsp_v (i_rsp_v), .i_rsp_r (i_rsp_r), .i_rsp_tag (i_rsp_tag),
        .o_rsp_v (o_rsp_v), .o_rsp_r (o_rsp_r), .o_rsp_sid (o_rsp_sid),
        .o_out_cnt (o_out_cnt), .o_err (o_err)
    );

    // Scoreboard: every handshaken output must match the oldest pending expectation
    always @(negedge clk) begin
        if (reset && o_req_v && o_req_r) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got tag %0d sid %0d ea %h, want no request", o_req_tag, o_req_sid, o_req_ea);
            end else begin
                req_exp_t e;
                e = req_q.pop_front();
                if ({o_req_tag, o_req_sid, o_req_ea} !== {e.tag, e.sid, e.ea}) begin
                    errors++;
                    $display("FAIL req_out: got tag %0d sid %0d ea %h, want tag %0d sid %0d ea %h",
                             o_req_tag, o_req_sid, o_req_ea, e.tag, e.sid, e.ea);
                end
            end
        end
        if (reset && o_rsp_v && o_rsp_r) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got sid %0d, want no response", o_rsp_sid);
            end else begin
                logic [SW-1:0] s;
                s = rsp_q.pop_front();
                if (o_rsp_sid !== s) begin
                    errors++;
                    $display("FAIL rsp_out: got sid %0d, want sid %0d", o_rsp_sid, s);
                end
            end
        end
    end

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req_v = '0; i_req_sid = '0; i_req_ea = '0;
        o_req_r = 1'b1; i_rsp_v = 1'b0; i_rsp_tag = '0; o_rsp_r = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_req(input int c, input logic [L2W-1:0] lsid, input logic [AW-1:0] ea);
        i_req_v[c] = 1'b1;
        i_req_sid[c*L2W +: L2W] = lsid;
        i_req_ea[c*AW +: AW] = ea;
    endtask

    task automatic push_req(input logic [TW-1:0] tag, input logic [SW-1:0] sid, input logic [AW-1:0] ea);
        req_exp_t e;
        e.tag = tag; e.sid = sid; e.ea = ea;
        req_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_req_v, o_rsp_v, o_err, o_out_cnt, i_req_r, i_rsp_r} !== {3'b000, 6'd0, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want %b", {o_req_v, o_rsp_v, o_err, o_out_cnt, i_req_r, i_rsp_r},
                     {3'b000, 6'd0, 4'b0000, 1'b1});
        end
        checks++;
        if ({o_req_tag, o_req_sid, o_req_ea, o_rsp_sid} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got tag %0d sid %0d ea %h rsp_sid %0d, want all 0", o_req_tag, o_req_sid, o_req_ea, o_rsp_sid);
        end
        drive_slot();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drive_slot();
        set_req(2, 4'd5, 64'h1000);
        push_req(5'd0, 6'd37, 64'h1000);
        @(negedge clk);
        checks++;
        if (i_req_r !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b, want %b", i_req_r, 4'b0100); end
        drive_slot();
        i_req_v = '0;
        @(negedge clk);
        checks++;
        if ({o_req_v, o_out_cnt} !== {1'b1, 6'd1}) begin
            errors++; $display("FAIL single_issue: got v %b cnt %0d, want v 1 cnt 1", o_req_v, o_out_cnt);
        end
        drive_slot();
        i_rsp_v = 1'b1; i_rsp_tag = 5'd0;
        rsp_q.push_back(6'd37);
        @(negedge clk);
        drive_slot();
        i_rsp_v = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_rsp_v, o_out_cnt} !== {1'b1, 6'd0}) begin
            errors++; $display("FAIL single_rsp: got v %b cnt %0d, want v 1 cnt 0", o_rsp_v, o_out_cnt);
        end
        drive_slot();
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive_slot();
            if (k == 0) begin
                for (int c = 0; c < 4; c++) set_req(c, 4'(c), 64'h1000_0000 + 64'(c));
            end
            push_req(5'(k), 6'((k % 4) * 16 + (k % 4)), 64'h1000_0000 + 64'(k % 4));
            @(negedge clk);
            checks++;
            if (i_req_r !== 4'(1 << (k % 4))) begin
                errors++; $display("FAIL rr_grant %0d: got %b, want %b", k, i_req_r, 4'(1 << (k % 4)));
            end
        end
        drive_slot();
        i_req_v = '0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            drive_slot();
            i_rsp_v = 1'b1; i_rsp_tag = 5'(k);
            rsp_q.push_back(6'((k % 4) * 16 + (k % 4)));
            @(negedge clk);
        end
        drive_slot();
        i_rsp_v = 1'b0;
        @(negedge clk);
        checks++;
        if (o_out_cnt !== 6'd0) begin errors++; $display("FAIL rr_drain_cnt: got %0d, want 0", o_out_cnt); end
        drive_slot();
        @(negedge clk);
    endtask

    task automatic test_tag_exhaustion();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            drive_slot();
            set_req(0, 4'(k % 16), 64'(k));
            push_req(5'(k), 6'(k % 16), 64'(k));
            @(negedge clk);
            checks++;
            if (i_req_r !== 4'b0001) begin errors++; $display("FAIL exh_ready %0d: got %b, want 0001", k, i_req_r); end
        end
        drive_slot();
        set_req(0, 4'd5, 64'h777);
        @(negedge clk);
        checks++;
        if ({i_req_r, o_out_cnt} !== {4'b0000, 6'd32}) begin
            errors++; $display("FAIL exh_full: got ready %b cnt %0d, want ready 0000 cnt 32", i_req_r, o_out_cnt);
        end
        drive_slot();
        i_rsp_v = 1'b1; i_rsp_tag = 5'd7;
        rsp_q.push_back(6'd7);
        @(negedge clk);
        checks++;
        if (i_req_r !== 4'b0000) begin errors++; $display("FAIL exh_free_cycle: got %b, want 0000", i_req_r); end
        drive_slot();
        i_rsp_v = 1'b0;
        push_req(5'd7, 6'd5, 64'h777);
        @(negedge clk);
        checks++;
        if ({i_req_r, o_out_cnt} !== {4'b0001, 6'd31}) begin
            errors++; $display("FAIL exh_after_free: got ready %b cnt %0d, want ready 0001 cnt 31", i_req_r, o_out_cnt);
        end
        drive_slot();
        i_req_v = '0;
        @(negedge clk);
        checks++;
        if (o_out_cnt !== 6'd32) begin errors++; $display("FAIL exh_refill: got %0d, want 32", o_out_cnt); end
        drive_slot();
        @(negedge clk);
    endtask

    task automatic test_stream_limit();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_slot();
            set_req(1, 4'd3, 64'h2000 + 64'(k));
            push_req(5'(k), 6'd19, 64'h2000 + 64'(k));
            @(negedge clk);
            checks++;
            if (i_req_r !== 4'b0010) begin errors++; $display("FAIL lim_ready %0d: got %b, want 0010", k, i_req_r); end
        end
        drive_slot();
        set_req(1, 4'd3, 64'h2004);
`ifdef L2_REQ_SCHED_STRM_LIMIT_EN
        @(negedge clk);
        checks++;
        if (i_req_r !== 4'b0000) begin errors++; $display("FAIL lim_stall: got %b, want 0000", i_req_r); end
        drive_slot();
        i_rsp_v = 1'b1; i_rsp_tag = 5'd0;
        rsp_q.push_back(6'd19);
        @(negedge clk);
        checks++;
        if (i_req_r !== 4'b0000) begin errors++; $display("FAIL lim_stall2: got %b, want 0000", i_req_r); end
        drive_slot();
        i_rsp_v = 1'b0;
        push_req(5'd0, 6'd19, 64'h2004);
        @(negedge clk);
        checks++;
        if (i_req_r !== 4'b0010) begin errors++; $display("FAIL lim_resume: got %b, want 0010", i_req_r); end
        drive_slot();
        i_req_v = '0;
        @(negedge clk);
`else
        push_req(5'd4, 6'd19, 64'h2004);
        @(negedge clk);
        checks++;
        if (i_req_r !== 4'b0010) begin errors++; $display("FAIL nolim_fifth: got %b, want 0010", i_req_r); end
        drive_slot();
        i_req_v = '0;
        @(negedge clk);
        checks++;
        if (o_out_cnt !== 6'd5) begin errors++; $display("FAIL nolim_cnt: got %0d, want 5", o_out_cnt); end
`endif
        drive_slot();
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        o_req_r = 1'b0;
        drive_slot();
        set_req(3, 4'd2, 64'hABC);
        push_req(5'd0, 6'd50, 64'hABC);
        @(negedge clk);
        checks++;
        if (i_req_r !== 4'b1000) begin errors++; $display("FAIL bp_first: got %b, want 1000", i_req_r); end
        for (int j = 1; j <= 5; j++) begin
            drive_slot();
            if (j == 1) set_req(3, 4'd4, 64'hDEF);
            @(negedge clk);
            checks++;
            if ({o_req_v, o_req_tag, o_req_sid, o_req_ea, i_req_r} !== {1'b1, 5'd0, 6'd50, 64'hABC, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold %0d: got v %b tag %0d sid %0d ea %h rdy %b, want v 1 tag 0 sid 50 ea abc rdy 0000",
                         j, o_req_v, o_req_tag, o_req_sid, o_req_ea, i_req_r);
            end
        end
        drive_slot();
        o_req_r = 1'b1;
        push_req(5'd1, 6'd52, 64'hDEF);
        @(negedge clk);
        checks++;
        if (i_req_r !== 4'b1000) begin errors++; $display("FAIL bp_release: got %b, want 1000", i_req_r); end
        drive_slot();
        i_req_v = '0;
        @(negedge clk);
        drive_slot();
        o_rsp_r = 1'b0;
        i_rsp_v = 1'b1; i_rsp_tag = 5'd0;
        rsp_q.push_back(6'd50);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            drive_slot();
            i_rsp_tag = 5'd1;
            @(negedge clk);
            checks++;
            if ({o_rsp_v, o_rsp_sid, i_rsp_r} !== {1'b1, 6'd50, 1'b0}) begin
                errors++; $display("FAIL bp_rsp_hold %0d: got v %b sid %0d rdy %b, want v 1 sid 50 rdy 0", j, o_rsp_v, o_rsp_sid, i_rsp_r);
            end
        end
        drive_slot();
        o_rsp_r = 1'b1;
        rsp_q.push_back(6'd52);
        @(negedge clk);
        checks++;
        if (i_rsp_r !== 1'b1) begin errors++; $display("FAIL bp_rsp_release: got %b, want 1", i_rsp_r); end
        drive_slot();
        i_rsp_v = 1'b0;
        @(negedge clk);
        drive_slot();
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive_slot();
        set_req(0, 4'd2, 64'h10);
        push_req(5'd0, 6'd2, 64'h10);
        @(negedge clk);
        drive_slot();
        i_req_v = '0;
        set_req(1, 4'd0, 64'h20);
        push_req(5'd1, 6'd16, 64'h20);
        i_rsp_v = 1'b1; i_rsp_tag = 5'd0;
        rsp_q.push_back(6'd2);
        @(negedge clk);
        checks++;
        if ({o_out_cnt, i_req_r} !== {6'd1, 4'b0010}) begin
            errors++; $display("FAIL simul_pre: got cnt %0d rdy %b, want cnt 1 rdy 0010", o_out_cnt, i_req_r);
        end
        drive_slot();
        i_req_v = '0; i_rsp_v = 1'b0;
        @(negedge clk);
        checks++;
        if (o_out_cnt !== 6'd1) begin errors++; $display("FAIL simul_cnt: got %0d, want 1", o_out_cnt); end
        drive_slot();
        @(negedge clk);
    endtask

    task automatic test_error_reset();
        do_reset();
        drive_slot();
        i_rsp_v = 1'b1; i_rsp_tag = 5'd12;
        @(negedge clk);
        drive_slot();
        i_rsp_v = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_rsp_v, o_err} !== 2'b01) begin errors++; $display("FAIL err_drop: got v %b err %b, want v 0 err 1", o_rsp_v, o_err); end
        drive_slot();
        o_req_r = 1'b0;
        set_req(0, 4'd1, 64'h55);
        @(negedge clk);
        drive_slot();
        i_req_v = '0;
        @(negedge clk);
        checks++;
        if ({o_req_v, o_out_cnt, o_err} !== {1'b1, 6'd1, 1'b1}) begin
            errors++; $display("FAIL err_pending: got v %b cnt %0d err %b, want v 1 cnt 1 err 1", o_req_v, o_out_cnt, o_err);
        end
        drive_slot();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_req_v, o_rsp_v, o_err, o_out_cnt, i_req_r, i_rsp_r, o_req_tag, o_req_sid, o_req_ea, o_rsp_sid} !==
            {3'b000, 6'd0, 4'b0000, 1'b1, 5'd0, 6'd0, 64'd0, 6'd0}) begin
            errors++;
            $display("FAIL mid_reset: got v %b rv %b err %b cnt %0d rdy %b rrdy %b tag %0d sid %0d ea %h, want all reset values",
                     o_req_v, o_rsp_v, o_err, o_out_cnt, i_req_r, i_rsp_r, o_req_tag, o_req_sid, o_req_ea);
        end
        drive_slot();
        reset = 1'b1;
        @(negedge clk);
        drive_slot();
        o_req_r = 1'b1;
        i_rsp_v = 1'b1; i_rsp_tag = 5'd0;
        @(negedge clk);
        drive_slot();
        i_rsp_v = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_rsp_v, o_err, o_out_cnt} !== {1'b0, 1'b1, 6'd0}) begin
            errors++; $display("FAIL forgotten_tag: got v %b err %b cnt %0d, want v 0 err 1 cnt 0", o_rsp_v, o_err, o_out_cnt);
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_tag_exhaustion();
        test_stream_limit();
        test_backpressure();
        test_simultaneous();
        test_error_reset();
        checks++;
        if (req_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d req %0d rsp pending, want 0 0", req_q.size(), rsp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
